// File: rtl/wb_pipe_sram_slave.sv
// rtl/wb_pipe_sram_slave.sv - Wishbone B4 pipelined SRAM slave with fixed-latency in-order responses
// Optional incrementing-burst address checking: WB_PIPE_SRAM_BURST_CHECK_EN
`timescale 1ns/1ps
module wb_pipe_sram_slave #(
    parameter int          ADDR_W          = 8,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          WAIT_STATES     = 2,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        CLK,
    input  logic        RST_ASYNC,
    input  logic        EN,
    input  logic [31:0] WB_ADR_IN,
    input  logic        WB_CYC_IN,
    input  logic        WB_STB_IN,
    input  logic        WB_WE_IN,
    input  logic [3:0]  WB_SEL_IN,
    input  logic [2:0]  WB_CTI_IN,
    input  logic [1:0]  WB_BTE_IN,
    input  logic [31:0] WB_DAT_WR_IN,
    output logic        WB_STALL_OUT,
    output logic        WB_ACK_OUT,
    output logic        WB_ERR_OUT,
    output logic [31:0] WB_DAT_RD_OUT
);
    localparam int L     = WAIT_STATES + 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Stage 0 is loaded at the accept edge; stage L drives the outputs.
    logic [L:0]       r_v;
    logic [L:0]       r_e;
    logic [31:0]      r_d [0:L];
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem [0:(1<<ADDR_W)-1];

    logic              w_stall;
    logic              w_accept;
    logic              w_base_err;
    logic              w_burst_err;
    logic              w_err_req;
    logic [ADDR_W-1:0] w_word;
    logic [31:0]       w_rdata;
    logic              w_out_v;

    assign w_stall    = ~EN | (r_count == MAX_CNT);
    assign w_accept   = EN & WB_CYC_IN & WB_STB_IN & ~w_stall;
    assign w_word     = WB_ADR_IN[ADDR_W+1:2];
    assign w_rdata    = r_mem[w_word];
    assign w_base_err = (WB_ADR_IN[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]) |
                        (WB_ADR_IN[1:0] != 2'b00);
    assign w_err_req  = w_base_err | w_burst_err;

`ifdef WB_PIPE_SRAM_BURST_CHECK_EN
    logic        r_in_burst;
    logic [31:0] r_burst_adr;

    assign w_burst_err = (r_in_burst & (WB_ADR_IN != r_burst_adr)) |
                         ((WB_CTI_IN == 3'b010) & (WB_BTE_IN != 2'b00));

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_in_burst  <= 1'b0;
            r_burst_adr <= 32'h0;
        end else if (EN) begin
            if (!WB_CYC_IN) begin
                r_in_burst <= 1'b0;
            end else if (w_accept) begin
                if (WB_CTI_IN == 3'b111) begin
                    r_in_burst <= 1'b0;
                end else if ((WB_CTI_IN == 3'b010) && (WB_BTE_IN == 2'b00)) begin
                    r_in_burst  <= 1'b1;
                    r_burst_adr <= WB_ADR_IN + 32'd4;
                end
            end
        end
    end
`else
    logic w_unused_burst;
    assign w_burst_err    = 1'b0;
    assign w_unused_burst = ^{WB_CTI_IN, WB_BTE_IN};
`endif

    always_ff @(posedge CLK) begin
        if (w_accept && WB_WE_IN && !w_err_req) begin
            for (int i = 0; i < 4; i++) begin
                if (WB_SEL_IN[i]) r_mem[w_word][8*i +: 8] <= WB_DAT_WR_IN[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_v     <= '0;
            r_e     <= '0;
            r_count <= '0;
            for (int i = 0; i <= L; i++) r_d[i] <= 32'h0;
        end else if (EN) begin
            if (!WB_CYC_IN) begin
                r_v     <= '0;
                r_count <= '0;
            end else begin
                r_v    <= {r_v[L-1:0], w_accept};
                r_e    <= {r_e[L-1:0], w_err_req};
                r_d[0] <= (w_accept && !WB_WE_IN && !w_err_req) ? w_rdata : 32'h0;
                for (int i = 1; i <= L; i++) r_d[i] <= r_d[i-1];
                // A response issues when it moves into the output stage.
                case ({w_accept, r_v[L-1]})
                    2'b10:   r_count <= r_count + ONE;
                    2'b01:   r_count <= r_count - ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign w_out_v       = r_v[L] & EN & WB_CYC_IN;
    assign WB_STALL_OUT  = w_stall;
    assign WB_ACK_OUT    = w_out_v & ~r_e[L];
    assign WB_ERR_OUT    = w_out_v & r_e[L];
    assign WB_DAT_RD_OUT = w_out_v ? r_d[L] : 32'h0;
endmodule
